sort_queue: RTL

//  Parametrised systolic insertion-sort priority queue with DEPTH slots, kept in descending key order.

---
 rtl/sort_pkg.sv | 30 +++
 rtl/sort_slot.sv | 85 ++++++++
 rtl/sort_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort_queue priority queue.
// Key compare order: primary key first, secondary key breaks ties, both unsigned.
package sort_pkg;

  localparam logic SLOT_EMPTY    = 1'b0;
  localparam logic SLOT_OCCUPIED = 1'b1;

  // Default key field widths; the key compare helper is sized from these.
  localparam int SORT_PRI_W = 8;
  localparam int SORT_SEC_W = 12;

  // Operation applied to the whole slot array in one cycle.
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSHPOP
  } op_e;

  // True when key a orders strictly ahead of key b.
  function automatic logic key_gt(
    input logic [SORT_PRI_W-1:0] pri_a,
    input logic [SORT_SEC_W-1:0] sec_a,
    input logic [SORT_PRI_W-1:0] pri_b,
    input logic [SORT_SEC_W-1:0] sec_b
  );
    return (pri_a > pri_b) || ((pri_a == pri_b) && (sec_a > sec_b));
  endfunction

endpackage

// File: rtl/sort_slot.sv
// One slot of the systolic sort array: state and data registers plus the
// local hold / take-prev / take-next / take-new selection. Each slot only
// looks at its immediate neighbours, the incoming entry and the operation.
// keep_o: this slot is occupied and its key is >= the incoming key, so the
// incoming entry belongs somewhere behind it (equal keys stay ahead: FIFO).
module sort_slot
  import sort_pkg::*;
#(
  parameter int PRI_W  = 8,
  parameter int SEC_W  = 12,
  parameter int DATA_W = 32,
  parameter bit HEAD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  op_e               op_i,
  input  logic [DATA_W-1:0] new_data_i,
  input  logic              prev_state_i,
  input  logic [DATA_W-1:0] prev_data_i,
  input  logic              prev_keep_i,
  input  logic              next_state_i,
  input  logic [DATA_W-1:0] next_data_i,
  input  logic              next_keep_i,
  output logic              state_o,
  output logic [DATA_W-1:0] data_o,
  output logic              keep_o
);

  logic              state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign keep_o  = (state_q == SLOT_OCCUPIED) &&
                   !key_gt(new_data_i[PRI_W+SEC_W-1:SEC_W], new_data_i[SEC_W-1:0],
                           data_q[PRI_W+SEC_W-1:SEC_W], data_q[SEC_W-1:0]);
  assign state_o = state_q;
  assign data_o  = data_q;

  // Next-slot selection. Push+pop works on the left-shifted view
  // v[i] = slot[i+1], so "keep" of the view at i is next_keep_i and the
  // view's predecessor at i is this slot itself (the head sees an implicit
  // always-keep predecessor).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (op_i)
      OP_PUSH: begin
        if (!keep_o) begin
          if (prev_keep_i) begin
            state_d = SLOT_OCCUPIED;
            data_d  = new_data_i;
          end else begin
            state_d = prev_state_i;
            data_d  = prev_data_i;
          end
        end
      end
      OP_POP: begin
        state_d = next_state_i;
        data_d  = next_data_i;
      end
      OP_PUSHPOP: begin
        if (next_keep_i) begin
          state_d = next_state_i;
          data_d  = next_data_i;
        end else if (keep_o || HEAD) begin
          state_d = SLOT_OCCUPIED;
          data_d  = new_data_i;
        end
      end
      default: ;
    endcase
  end

  // Slot registers, cleared to EMPTY / zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sort_queue.sv
// Systolic insertion-sort priority queue, descending key order, head at slot 0.
// Optional tail-drop mode is enabled by defining SORT_DROP_EN: pushes are then
// always accepted and a push into a full queue evicts either the tail or the
// new entry itself, reported for one cycle on drop_valid/drop_data.
//
// Handshake: a push happens on a rising edge where in_valid && in_ready; a pop
// happens on a rising edge where out_valid && out_ready. Both may happen in the
// same cycle. in_ready depends combinationally on out_ready.
module sort_queue
  import sort_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PRI_W  = 8,
  parameter int SEC_W  = 12,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef SORT_DROP_EN
  ,
  output logic                       drop_valid,
  output logic [DATA_W-1:0]          drop_data
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic              push, pop;
  op_e               op;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  st, kp;
  logic [DATA_W-1:0] dt [DEPTH];
  logic [DEPTH-1:0]  prev_st, prev_kp, next_st, next_kp;
  logic [DATA_W-1:0] prev_dt [DEPTH];
  logic [DATA_W-1:0] next_dt [DEPTH];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

`ifdef SORT_DROP_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = !full || out_ready;
`endif

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = st[0];
  assign out_data  = dt[0];

  // Encode this cycle's array operation from the qualified handshakes.
  always_comb begin
    op = OP_IDLE;
    if (push && pop)  op = OP_PUSHPOP;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_first
      assign prev_st[i] = SLOT_EMPTY;
      assign prev_dt[i] = '0;
      assign prev_kp[i] = 1'b1;
    end else begin : g_inner_prev
      assign prev_st[i] = st[i-1];
      assign prev_dt[i] = dt[i-1];
      assign prev_kp[i] = kp[i-1];
    end
    if (i == DEPTH-1) begin : g_last
      assign next_st[i] = SLOT_EMPTY;
      assign next_dt[i] = '0;
      assign next_kp[i] = 1'b0;
    end else begin : g_inner_next
      assign next_st[i] = st[i+1];
      assign next_dt[i] = dt[i+1];
      assign next_kp[i] = kp[i+1];
    end

    sort_slot #(
      .PRI_W (PRI_W),
      .SEC_W (SEC_W),
      .DATA_W(DATA_W),
      .HEAD  (i == 0)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .op_i        (op),
      .new_data_i  (in_data),
      .prev_state_i(prev_st[i]),
      .prev_data_i (prev_dt[i]),
      .prev_keep_i (prev_kp[i]),
      .next_state_i(next_st[i]),
      .next_data_i (next_dt[i]),
      .next_keep_i (next_kp[i]),
      .state_o     (st[i]),
      .data_o      (dt[i]),
      .keep_o      (kp[i])
    );
  end

  // Occupancy: a push into a full queue (drop mode) leaves count at DEPTH.
  always_comb begin
    count_d = count_q;
    case (op)
      OP_PUSH: if (!full) count_d = count_q + CNT_W'(1);
      OP_POP:  count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Occupancy counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

`ifdef SORT_DROP_EN
  logic              drop_valid_q, drop_valid_d;
  logic [DATA_W-1:0] drop_data_q, drop_data_d;

  // Drop selection: if the tail keeps ahead of the new entry, the new entry
  // is the one lost; otherwise the tail falls off the end of the array.
  always_comb begin
    drop_valid_d = (op == OP_PUSH) && full;
    drop_data_d  = kp[DEPTH-1] ? in_data : dt[DEPTH-1];
  end

  // One-cycle drop report register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_valid_q <= 1'b0;
      drop_data_q  <= '0;
    end else begin
      drop_valid_q <= drop_valid_d;
      drop_data_q  <= drop_valid_d ? drop_data_d : drop_data_q;
    end
  end

  assign drop_valid = drop_valid_q;
  assign drop_data  = drop_data_q;
`endif

endmodule
